nf_reg_file_sb: RTL and testbench
=================================

# nf_reg_file_sb

Parametrised general-purpose register file for the nanoFOX core, with a per-register pending-write scoreboard and a hardware clear engine. It replaces the fixed 32×32 register file in the decode stage. Two operand read ports and one debug read port are combinational. Load-use hazards are tracked in the scoreboard, and every register is guaranteed to be zero after reset or on request.

## Interface
Parameters:
- XLEN, 32, register width in bits
- REG_NUM, 32, number of registers; power of two, 2..64
- AW, $clog2(REG_NUM), address width (derived; do not override)
- ZERO_REG, 1, 1: register 0 reads 0, is never written and is never pending
- BYPASS, 1, 1: same-cycle write data is forwarded to the read ports

Ports:
- clk  in  1  core clock
- resetn  in  1  asynchronous, active-low reset
- clr_req  in  1  pulse; restarts the clear engine (ignored while not ready)
- ready  out  1  1 = clear finished, file accepting writes
- ra1 / ra2 / ra0  in  AW  read addresses (ports 1 and 2 are operands, port 0 is debug)
- rd1 / rd2 / rd0  out  XLEN  read data
- busy1 / busy2  out  1  register at ra1 / ra2 has a pending write
- wa3  in  AW  write address
- wd3  in  XLEN  write data
- we3  in  1  write enable
- set_pend  in  1  mark register set_addr pending (load issued)
- set_addr  in  AW  register to mark pending

## Operation
- FSM states:
  - CLEAR: clear counter cnt writes 0 to reg[cnt] each cycle; cnt increments.
  - RUN: normal operation.
- FSM transitions:
  - Reset enters CLEAR with cnt = 0.
  - CLEAR → RUN after the cycle with cnt = REG_NUM-1.
  - RUN → CLEAR on clr_req = 1; cnt is reset to 0.
- In CLEAR:
  - we3 and set_pend are ignored.
  - pend[] is held at 0.
  - rd0/rd1/rd2 = 0, busy1/busy2 = 0.
- Write (RUN, we3 = 1): reg[wa3] ← wd3 at posedge and pend[wa3] ← 0. If ZERO_REG = 1 and wa3 = 0, the write is dropped.
- Scoreboard (RUN, set_pend = 1): pend[set_addr] ← 1. If ZERO_REG = 1 and set_addr = 0, nothing happens.
- Simultaneous set_pend and we3 to the same address: set wins. The data is written and pend = 1.
- Read rdN:
  - 0 if in CLEAR, or if ZERO_REG = 1 and raN = 0.
  - Otherwise wd3, if BYPASS = 1, we3 = 1 and raN = wa3.
  - Otherwise reg[raN].
- busyN = pend[raN] & ~(we3 & raN = wa3). A forwarding write hides busy only when BYPASS = 1; when BYPASS = 0, busyN = pend[raN].
- clr_req received while already in CLEAR is ignored. It does not restart the count.
- Addresses are unsigned and never wrap. cnt width is AW+1 so REG_NUM-1 is detected without overflow.

## Timing
- Reset values:
  - ready = 0, cnt = 0, pend = 0.
  - rd0/rd1/rd2 = 0, busy1/busy2 = 0.
- Array contents are undefined during reset and are zeroed by CLEAR.
- Clear latency:
  - ready rises at the posedge REG_NUM cycles after the first posedge with resetn = 1 (after 32 cycles by default).
  - After clr_req, ready falls at the next posedge and rises again REG_NUM cycles later.
- Read ports are combinational, with zero latency.
- A write is visible via bypass in the same cycle and from the array on the next cycle.
- pend set or clear takes effect at the posedge, so busy reflects it in the following cycle.
- resetn asserted mid-CLEAR or mid-RUN:
  - Immediate async return to CLEAR with cnt = 0, ready = 0 and pend cleared.
  - The clear restarts from register 0.

## Test plan
- Reset release:
  - ready = 0 for 32 cycles, then 1.
  - All 32 registers read 0 on rd0.
  - we3 with wa3 = 5, wd3 = 0xDEADBEEF issued during CLEAR leaves reg5 = 0.
- Write/read with bypass:
  - Cycle N: we3, wa3 = 7, wd3 = 0x12345678, ra1 = 7 → rd1 = 0x12345678 in cycle N.
  - Cycle N+1, we3 = 0 → rd1 = 0x12345678.
  - Write to reg0 → rd reads 0.
- Scoreboard:
  - set_pend, set_addr = 9 → busy1 = 1 (ra1 = 9) from the next cycle.
  - we3 with wa3 = 9 → busy1 = 0 in that same cycle and afterwards.
  - set_pend and we3 both to reg 9 in the same cycle → pend stays 1 and reg9 is updated.
- clr_req in RUN with reg3 = 0xA5A5A5A5 and pend[4] = 1:
  - ready = 0 for 32 cycles.
  - Afterwards reg3 = 0 and busy for reg 4 = 0.
- Reset mid-CLEAR:
  - resetn low at cycle 10 of CLEAR → ready = 0 and pend = 0 immediately.
  - After release, ready rises exactly 32 cycles later.
- Parameter sweep:
  - XLEN = 64, REG_NUM = 16, ZERO_REG = 0, BYPASS = 0.
  - Reg0 is writable (holds 0xFFFF_FFFF_FFFF_FFFF).
  - Same-cycle read returns the old value.
  - ready rises after 16 cycles.

Source files
------------

// File: rtl/nf_reg_file_sb.sv
// Register file with pending-write scoreboard and clear engine; reads are combinational (0 cycles), writes land at posedge.
// No backpressure: while the clear sweep runs, ready is low, writes/set_pend are dropped and all reads return 0.
module nf_reg_file_sb #(
    parameter int XLEN     = 32,
    parameter int REG_NUM  = 32,
    parameter int AW       = $clog2(REG_NUM),
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            clr_req,
    output logic            ready,
    input  logic [AW-1:0]   ra1,
    input  logic [AW-1:0]   ra2,
    input  logic [AW-1:0]   ra0,
    output logic [XLEN-1:0] rd1,
    output logic [XLEN-1:0] rd2,
    output logic [XLEN-1:0] rd0,
    output logic            busy1,
    output logic            busy2,
    input  logic [AW-1:0]   wa3,
    input  logic [XLEN-1:0] wd3,
    input  logic            we3,
    input  logic            set_pend,
    input  logic [AW-1:0]   set_addr
);

    localparam logic [0:0]  ST_CLEAR = 1'b0;
    localparam logic [0:0]  ST_RUN   = 1'b1;
    localparam logic [AW:0] CNT_LAST = (AW+1)'(REG_NUM - 1);
    localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);

    logic [0:0]         state;
    logic [AW:0]        cnt;
    logic [REG_NUM-1:0] pend;
    logic [XLEN-1:0]    mem [REG_NUM];
    logic               wr_ok;
    logic               set_ok;

    assign ready  = (state == ST_RUN);
    assign wr_ok  = ready && we3 && !((ZERO_REG != 0) && (wa3 == '0));
    assign set_ok = ready && set_pend && !((ZERO_REG != 0) && (set_addr == '0));

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= ST_CLEAR;
            cnt   <= '0;
        end else if (state == ST_CLEAR) begin
            cnt <= cnt + CNT_ONE;
            if (cnt == CNT_LAST) begin
                state <= ST_RUN;
            end
        end else if (clr_req) begin
            state <= ST_CLEAR;
            cnt   <= '0;
        end
    end

    // Set is applied after clear so a same-cycle load issue keeps the register pending.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pend <= '0;
        end else if (!ready || clr_req) begin
            pend <= '0;
        end else begin
            if (wr_ok) begin
                pend[wa3] <= 1'b0;
            end
            if (set_ok) begin
                pend[set_addr] <= 1'b1;
            end
        end
    end

    // Array has no reset; the clear sweep is what guarantees zero contents.
    always_ff @(posedge clk) begin
        if (state == ST_CLEAR) begin
            mem[cnt[AW-1:0]] <= '0;
        end else if (wr_ok) begin
            mem[wa3] <= wd3;
        end
    end

    function automatic logic fwd(input logic [AW-1:0] ra);
        return (BYPASS != 0) && we3 && (ra == wa3);
    endfunction

    function automatic logic [XLEN-1:0] rd_mux(input logic [AW-1:0] ra);
        if (!ready || ((ZERO_REG != 0) && (ra == '0))) begin
            return '0;
        end else if (fwd(ra)) begin
            return wd3;
        end else begin
            return mem[ra];
        end
    endfunction

    always_comb begin
        rd0   = rd_mux(ra0);
        rd1   = rd_mux(ra1);
        rd2   = rd_mux(ra2);
        busy1 = ready && pend[ra1] && !fwd(ra1);
        busy2 = ready && pend[ra2] && !fwd(ra2);
    end

endmodule

// File: tb/tb_nf_reg_file_sb.sv
// Directed bench for nf_reg_file_sb: default instance plus a 64-bit/16-entry, no-zero-reg, no-bypass instance.
module tb_nf_reg_file_sb;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        resetn, clr_req, we3, set_pend;
    logic [4:0]  ra0, ra1, ra2, wa3, set_addr;
    logic [31:0] wd3, rd0, rd1, rd2;
    logic        ready, busy1, busy2;

    logic        resetn_b, clr_req_b, we3_b, set_pend_b;
    logic [3:0]  ra0_b, ra1_b, ra2_b, wa3_b, set_addr_b;
    logic [63:0] wd3_b, rd0_b, rd1_b, rd2_b;
    logic        ready_b, busy1_b, busy2_b;

    int tests = 0;
    int fails = 0;
    int n;

    nf_reg_file_sb dut_a (
        .clk(clk), .resetn(resetn), .clr_req(clr_req), .ready(ready),
        .ra1(ra1), .ra2(ra2), .ra0(ra0), .rd1(rd1), .rd2(rd2), .rd0(rd0),
        .busy1(busy1), .busy2(busy2), .wa3(wa3), .wd3(wd3), .we3(we3),
        .set_pend(set_pend), .set_addr(set_addr)
    );

    nf_reg_file_sb #(.XLEN(64), .REG_NUM(16), .ZERO_REG(0), .BYPASS(0)) dut_b (
        .clk(clk), .resetn(resetn_b), .clr_req(clr_req_b), .ready(ready_b),
        .ra1(ra1_b), .ra2(ra2_b), .ra0(ra0_b), .rd1(rd1_b), .rd2(rd2_b), .rd0(rd0_b),
        .busy1(busy1_b), .busy2(busy2_b), .wa3(wa3_b), .wd3(wd3_b), .we3(we3_b),
        .set_pend(set_pend_b), .set_addr(set_addr_b)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Counts posedges until ready of the selected instance goes high (bounded).
    task automatic count_ready(input bit sel_b, output int cycles);
        cycles = 0;
        while (cycles < 64 && !(sel_b ? ready_b : ready)) begin
            tick();
            cycles++;
        end
    endtask

    initial begin
        resetn = 1'b0; clr_req = 1'b0; we3 = 1'b0; set_pend = 1'b0;
        ra0 = '0; ra1 = '0; ra2 = '0; wa3 = '0; set_addr = '0; wd3 = '0;
        resetn_b = 1'b0; clr_req_b = 1'b0; we3_b = 1'b0; set_pend_b = 1'b0;
        ra0_b = '0; ra1_b = '0; ra2_b = '0; wa3_b = '0; set_addr_b = '0; wd3_b = '0;

        #1;
        chk("rst_ready", 64'(ready), 64'd0);
        chk("rst_rd1", 64'(rd1), 64'd0);
        chk("rst_busy1", 64'(busy1), 64'd0);
        tick(); tick();

        // Reset release with an ignored write during the sweep
        resetn = 1'b1;
        repeat (10) tick();
        we3 = 1'b1; wa3 = 5'd5; wd3 = 32'hDEADBEEF;
        repeat (10) tick();
        we3 = 1'b0;
        chk("clear_ready_low", 64'(ready), 64'd0);
        count_ready(1'b0, n);
        chk("ready_rise_cycles", 64'(n + 20), 64'd32);
        for (int i = 0; i < 32; i++) begin
            ra0 = 5'(i);
            #1;
            chk($sformatf("zero_reg%0d", i), 64'(rd0), 64'd0);
        end
        ra0 = 5'd5; #1;
        chk("reg5_write_ignored", 64'(rd0), 64'd0);

        // Write/read with bypass
        ra1 = 5'd7; ra0 = 5'd7; we3 = 1'b1; wa3 = 5'd7; wd3 = 32'h12345678;
        #1;
        chk("bypass_rd1", 64'(rd1), 64'h12345678);
        chk("bypass_rd0", 64'(rd0), 64'h12345678);
        tick();
        we3 = 1'b0; #1;
        chk("array_rd1", 64'(rd1), 64'h12345678);
        ra1 = 5'd0; we3 = 1'b1; wa3 = 5'd0; wd3 = 32'hFFFFFFFF; #1;
        chk("reg0_bypass_zero", 64'(rd1), 64'd0);
        tick();
        we3 = 1'b0; #1;
        chk("reg0_stays_zero", 64'(rd1), 64'd0);

        // Scoreboard
        ra1 = 5'd9; ra2 = 5'd9; set_pend = 1'b1; set_addr = 5'd9; #1;
        chk("pend_not_yet", 64'(busy1), 64'd0);
        tick();
        set_pend = 1'b0; #1;
        chk("busy1_set", 64'(busy1), 64'd1);
        chk("busy2_set", 64'(busy2), 64'd1);
        we3 = 1'b1; wa3 = 5'd9; wd3 = 32'h00000099; #1;
        chk("busy1_hidden_by_write", 64'(busy1), 64'd0);
        chk("rd1_write_fwd", 64'(rd1), 64'h99);
        tick();
        we3 = 1'b0; #1;
        chk("busy1_cleared", 64'(busy1), 64'd0);
        set_pend = 1'b1; set_addr = 5'd9; we3 = 1'b1; wa3 = 5'd9; wd3 = 32'h000000AB;
        tick();
        set_pend = 1'b0; we3 = 1'b0; #1;
        chk("set_wins_busy", 64'(busy1), 64'd1);
        chk("set_wins_data", 64'(rd1), 64'hAB);

        // Clear request from RUN, with an ignored re-request mid-sweep
        ra1 = 5'd3; ra2 = 5'd4;
        we3 = 1'b1; wa3 = 5'd3; wd3 = 32'hA5A5A5A5; set_pend = 1'b1; set_addr = 5'd4;
        tick();
        we3 = 1'b0; set_pend = 1'b0; #1;
        chk("pre_clr_reg3", 64'(rd1), 64'hA5A5A5A5);
        chk("pre_clr_busy4", 64'(busy2), 64'd1);
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0; #1;
        chk("clr_ready_fall", 64'(ready), 64'd0);
        chk("clr_rd_zero", 64'(rd1), 64'd0);
        repeat (5) tick();
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        count_ready(1'b0, n);
        chk("clr_ready_cycles", 64'(n + 6), 64'd32);
        #1;
        chk("post_clr_reg3", 64'(rd1), 64'd0);
        chk("post_clr_busy4", 64'(busy2), 64'd0);
        ra1 = 5'd9; ra0 = 5'd9; #1;
        chk("post_clr_busy9", 64'(busy1), 64'd0);
        chk("post_clr_reg9", 64'(rd0), 64'd0);

        // Async reset during RUN with a pending register
        set_pend = 1'b1; set_addr = 5'd4;
        tick();
        set_pend = 1'b0; #1;
        chk("run_busy4", 64'(busy2), 64'd1);
        #2 resetn = 1'b0;
        #1;
        chk("run_rst_ready", 64'(ready), 64'd0);
        chk("run_rst_busy", 64'(busy2), 64'd0);
        tick();
        resetn = 1'b1;
        count_ready(1'b0, n);
        chk("run_rst_ready_cycles", 64'(n), 64'd32);
        chk("run_rst_pend_gone", 64'(busy2), 64'd0);

        // Async reset at cycle 10 of a clear sweep
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        repeat (10) tick();
        #2 resetn = 1'b0;
        #1;
        chk("mid_clr_rst_ready", 64'(ready), 64'd0);
        chk("mid_clr_rst_busy", 64'(busy2), 64'd0);
        tick(); tick();
        resetn = 1'b1;
        count_ready(1'b0, n);
        chk("mid_clr_ready_cycles", 64'(n), 64'd32);

        // Parameter sweep instance: 64-bit, 16 regs, no zero reg, no bypass
        resetn_b = 1'b1;
        count_ready(1'b1, n);
        chk("b_ready_cycles", 64'(n), 64'd16);
        ra1_b = 4'd0; we3_b = 1'b1; wa3_b = 4'd0; wd3_b = 64'hFFFF_FFFF_FFFF_FFFF; #1;
        chk("b_no_bypass_old", rd1_b, 64'd0);
        tick();
        we3_b = 1'b0; #1;
        chk("b_reg0_writable", rd1_b, 64'hFFFF_FFFF_FFFF_FFFF);
        ra1_b = 4'd2; set_pend_b = 1'b1; set_addr_b = 4'd2;
        tick();
        set_pend_b = 1'b0; #1;
        chk("b_busy_set", 64'(busy1_b), 64'd1);
        we3_b = 1'b1; wa3_b = 4'd2; wd3_b = 64'h1122_3344_5566_7788; #1;
        chk("b_busy_not_hidden", 64'(busy1_b), 64'd1);
        chk("b_same_cycle_old", rd1_b, 64'd0);
        tick();
        we3_b = 1'b0; #1;
        chk("b_busy_cleared", 64'(busy1_b), 64'd0);
        chk("b_written", rd1_b, 64'h1122_3344_5566_7788);
        ra2_b = 4'd0; set_pend_b = 1'b1; set_addr_b = 4'd0;
        tick();
        set_pend_b = 1'b0; #1;
        chk("b_reg0_pend", 64'(busy2_b), 64'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
